// File: rtl/csa_pipe_adder.sv
// Pipelined carry-save adder: a 3:2 compressor row into sum/carry registers, then carry-propagate.
// Define CSA_PIPE_OUTREG_EN to register the resolved result (latency 2, capacity 2).
module csa_pipe_adder_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ z;
    assign co = (x & y) | (x & z) | (y & z);
endmodule

module csa_pipe_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_sum,
    output logic             out_mode
);
    // acc_c's top bit would weigh 2^WIDTH, which is lost mod 2^WIDTH, so it is never kept.
    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-2:0] acc_c;
    logic [WIDTH-1:0] op_y, op_z, fa_s, fa_c;
    logic [WIDTH-1:0] s1_s, s1_c;
    logic             s1_valid, s1_mode;
    logic             in_fire, s1_adv;
    logic [WIDTH+1:0] full_sum, resolved;

    always_comb begin
        op_y = b;
        op_z = c;
        if (mode) begin
            op_y = acc_clr ? '0 : acc_s;
            op_z = acc_clr ? '0 : {acc_c, 1'b0};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        csa_pipe_adder_fa u_fa (
            .x  (a[i]),
            .y  (op_y[i]),
            .z  (op_z[i]),
            .s  (fa_s[i]),
            .co (fa_c[i])
        );
    end

    assign in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_c     <= '0;
            s1_mode  <= 1'b0;
            acc_s    <= '0;
            acc_c    <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_s     <= fa_s;
                s1_c     <= fa_c;
                s1_mode  <= mode;
                if (mode) begin
                    acc_s <= fa_s;
                    acc_c <= fa_c[WIDTH-2:0];
                end
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Mode 0 keeps both carry-out bits; accumulate wraps mod 2^WIDTH.
    assign full_sum = {2'b00, s1_s} + {1'b0, s1_c, 1'b0};
    assign resolved = s1_mode ? {2'b00, full_sum[WIDTH-1:0]} : full_sum;

`ifdef CSA_PIPE_OUTREG_EN
    logic s2_free;
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign s1_adv   = s1_valid && s2_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mode  <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_sum   <= resolved;
            out_mode  <= s1_mode;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready  = !s1_valid || out_ready;
    assign s1_adv    = s1_valid && out_ready;
    assign out_valid = s1_valid;
    assign out_sum   = resolved;
    assign out_mode  = s1_mode;
`endif
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder: driver pushes expected results, negedge monitor checks them.
module tb_csa_pipe_adder;
    localparam int W = 8;
`ifdef CSA_PIPE_OUTREG_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [W+1:0] sum;
        logic         mode;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         mode = 1'b0;
    logic         acc_clr = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic         in_ready, out_valid, out_mode;
    logic [W+1:0] out_sum;

    exp_t         sb[$];
    logic [W-1:0] model_acc = '0;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    bit           rand_rdy = 1'b0;

    csa_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition; accumulator kept as a binary value mod 2^W.
    task automatic push_exp(input logic m, input logic clr, input logic [W-1:0] x, y, z);
        exp_t e;
        logic [W+1:0] t;
        if (!m) begin
            t = {2'b00, x};
            t = t + {2'b00, y};
            t = t + {2'b00, z};
        end else begin
            model_acc = (clr ? '0 : model_acc) + x;
            t = {2'b00, model_acc};
        end
        e.sum  = t;
        e.mode = m;
        sb.push_back(e);
    endtask

    task automatic send(input logic m, input logic clr, input logic [W-1:0] x, y, z);
        int n;
        n = 0;
        in_valid = 1'b1; mode = m; acc_clr = clr; a = x; b = y; c = z;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(m, clr, x, y, z);
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL send_timeout: in_ready got 0 expected 1");
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained_queue_size", sb.size(), 0);
    endtask

    // Monitor: pops on every output handshake, and checks held data while stalled.
    logic         stalled = 1'b0;
    logic [W+1:0] held_sum = '0;
    logic         held_mode = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_sum_stable", out_sum, held_sum);
                check("stall_mode_stable", out_mode, held_mode);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", out_sum);
                end else begin
                    e = sb.pop_front();
                    check("out_sum", out_sum, e.sum);
                    check("out_mode", out_mode, e.mode);
                end
            end
            stalled   = out_valid && !out_ready;
            held_sum  = out_sum;
            held_mode = out_mode;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1);
    end

    initial begin
        int lat, accepts, t0;
        logic acc_now;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_mode", out_mode, 0);
        @(posedge clk); #1;

        // Largest mode-0 sum and its latency.
        send(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT);
        check("max_sum", out_sum, 32'h2FD);
        check("max_mode", out_mode, 0);
        drain();

        // Back-to-back accumulate with wrap.
        t0 = cyc;
        send(1'b1, 1'b1, 8'h10, 8'h00, 8'h00);
        send(1'b1, 1'b0, 8'h20, 8'hAA, 8'h55);
        send(1'b1, 1'b0, 8'hF0, 8'h00, 8'h00);
        check("b2b_cycles", cyc - t0, 3);
        drain();

        // Random mode-0 stream with gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Backpressure: pipe fills to capacity, then drains in order.
        out_ready = 1'b0;
        accepts = 0;
        in_valid = 1'b1; mode = 1'b0; acc_clr = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        repeat (5) begin
            @(negedge clk);
            acc_now = in_ready;
            if (acc_now) begin
                push_exp(1'b0, 1'b0, a, b, c);
                accepts++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            end
        end
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepts", accepts, CAP);
        out_ready = 1'b1;
        drain();

        // Mode-0 beat between accumulate beats leaves the accumulator alone.
        send(1'b1, 1'b1, 8'h05, 8'h00, 8'h00);
        send(1'b0, 1'b0, 8'h01, 8'h02, 8'h03);
        send(1'b1, 1'b0, 8'h07, 8'h00, 8'h00);
        drain();

        // Reset with beats in flight and a nonzero accumulator.
        out_ready = 1'b0;
        send(1'b1, 1'b1, 8'h09, 8'h00, 8'h00);
        for (int i = 1; i < CAP; i++) send(1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        model_acc = '0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b1, 1'b0, 8'h03, 8'h00, 8'h00);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("post_rst_acc_sum", out_sum, 32'h003);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
